// File: rtl/seg_io_ctrl_if.sv
// Display controller IO bus: one-cycle read/write strobes,
// byte address, write data and registered read data.
interface seg_io_ctrl_if;
  logic        io_write;
  logic        io_read;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output io_write,
    output io_read,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  io_write,
    input  io_read,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/seg_io_ctrl.sv
// Seven-segment display controller: staged 24-bit value, atomic commit
// with 7-digit clamp, blink generator. Ports: clk, rst (async low), bus, num, enable.
module seg_io_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FC80,
  parameter int unsigned BLINK_HALF = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  seg_io_ctrl_if.slave        bus,
  output logic [23:0]         num,
  output logic                enable
);

  localparam int unsigned CW = $clog2(BLINK_HALF);
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);
  localparam logic [23:0] MAX = 24'd9_999_999;

  typedef enum logic {
    SHOW = 1'b0,
    HIDE = 1'b1
  } phase_t;

  logic [23:0]   stage;
  logic          on;
  logic          blink;
  logic          ovf;
  phase_t        phase;
  logic [CW-1:0] bcnt;

  logic          hit;
  logic          wr;
  logic          rd;
  logic [1:0]    off;
  logic          sel_lo;
  logic          sel_hi;
  logic          sel_ctrl;
  logic          sel_stat;
  logic          commit;
  logic          big;

  logic          on_n;
  logic          blink_n;
  phase_t        phase_n;
  logic [CW-1:0] bcnt_n;

  logic          unused;
  assign unused = ^{bus.addr[1:0], bus.wdata[31:16]};

  assign hit      = bus.addr[31:4] == BASE_ADDR[31:4];
  assign off      = bus.addr[3:2];
  assign wr       = bus.io_write & hit;
  assign rd       = bus.io_read & hit;
  assign sel_lo   = off == 2'd0;
  assign sel_hi   = off == 2'd1;
  assign sel_ctrl = off == 2'd2;
  assign sel_stat = off == 2'd3;
  assign commit   = wr & sel_ctrl & bus.wdata[2];
  assign big      = stage > MAX;

  // Counting only continues while blinking was active before and
  // after this edge, so the edge that turns blink on starts at 0.
  always_comb begin
    on_n    = on;
    blink_n = blink;
    if (wr && sel_ctrl) begin
      on_n    = bus.wdata[0];
      blink_n = bus.wdata[1];
    end
    phase_n = phase;
    bcnt_n  = bcnt + 1'b1;
    if (!on_n || !blink_n || !on || !blink || commit) begin
      phase_n = SHOW;
      bcnt_n  = '0;
    end else if (bcnt == LAST) begin
      phase_n = phase_t'(~phase);
      bcnt_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage     <= '0;
      on        <= 1'b0;
      blink     <= 1'b0;
      ovf       <= 1'b0;
      phase     <= SHOW;
      bcnt      <= '0;
      num       <= '0;
      enable    <= 1'b0;
      bus.rdata <= '0;
    end else begin
      on     <= on_n;
      blink  <= blink_n;
      phase  <= phase_n;
      bcnt   <= bcnt_n;
      enable <= on_n & (phase_n == SHOW);

      if (wr && sel_lo) stage[15:0]  <= bus.wdata[15:0];
      if (wr && sel_hi) stage[23:16] <= bus.wdata[7:0];

      if (commit) num <= big ? MAX : stage;

      // A set from commit beats a clear from a STATUS read.
      if (commit && big)
        ovf <= 1'b1;
      else if (rd && sel_stat)
        ovf <= 1'b0;

      if (rd) begin
        unique case (1'b1)
          sel_lo:   bus.rdata <= {16'd0, stage[15:0]};
          sel_hi:   bus.rdata <= {24'd0, stage[23:16]};
          sel_ctrl: bus.rdata <= {30'd0, blink, on};
          sel_stat: bus.rdata <= {30'd0, ovf, phase == HIDE};
          default:  bus.rdata <= bus.rdata;
        endcase
      end
    end
  end

endmodule
